fp_normalize_serial: RTL and testbench
======================================

# fp_normalize_serial

Sequential normalizer that converts a 12-bit two's-complement sample into the sign, 3-bit exponent, 4-bit significand and round (extra) bit consumed by the rounding stage of the 8-bit floating-point converter. It sits directly upstream of the rounding stage. It accepts one sample per valid/ready handshake. It finds the leading one by shifting the magnitude left one bit per cycle, then presents the result on a valid/ready output held stable until consumed.

## Interface
- Parameters: none; widths fixed (input 12, magnitude 11, exponent 3, significand 4).
- `clk` in 1 — single clock, all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_data` in 12 — two's-complement sample.
- `in_valid` in 1 — sample present.
- `in_ready` out 1 — block can accept; `(state==IDLE) && !rst`.
- `out_sign` out 1 — sign bit (`in_data[11]`).
- `out_exp` out 3 — exponent 0..7.
- `out_significand` out 4 — four bits starting at the leading one.
- `out_xbit` out 1 — bit immediately below the significand (round bit).
- `out_valid` out 1 — result present.
- `out_ready` in 1 — downstream consumes result.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset → IDLE.
- IDLE: on `in_valid && in_ready`, register `sign = in_data[11]`, `mag = |in_data|` (11 bits), `exp = 7`; go to SHIFT.
- Magnitude: `-in_data` for negative inputs. 12'h800 (-2048) saturates to 11'h7FF, so it never wraps.
- SHIFT, each cycle: if `mag[10]==1` or `exp==0`, latch `out_significand = mag[10:7]`, `out_xbit = mag[6]`, `out_exp = exp`, `out_sign = sign`, then go to DONE. Otherwise `mag <= mag<<1` (zero fill) and `exp <= exp-1`.
- `exp` never decrements below 0. At exp 0 the significand equals the original `mag[3:0]` and xbit is 0.
- DONE: `out_valid=1`; outputs frozen. On `out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. There is no combinational path from inputs to outputs.
- Output registers change only on the SHIFT→DONE transition and on reset.

## Timing
- Reset values: `out_sign=0`, `out_exp=0`, `out_significand=0`, `out_xbit=0`, `out_valid=0`. `in_ready=0` while `rst` is high and 1 in the first cycle after release.
- Let N be the number of shifts (0..7); N = min(leading zeros of the 12-bit magnitude − 1, 7).
- Accept on edge E0. `out_valid` rises after edge E(N+1), so latency is 1..8 cycles.
- Handshake completes on the edge where `out_valid && out_ready`. `out_valid` falls and `in_ready` rises after that edge.
- Earliest next accept is one cycle later. There is no accept in the same cycle as output completion.
- Throughput is at most one sample per N+3 cycles.
- `rst` in any state: after that edge, state is IDLE, all outputs take their reset values, and no `out_valid` is produced for the aborted sample.
- `rst` takes priority over simultaneous `in_valid` or `out_ready`.

## Structure
- Shared package `fp_pkg` holds:
  - constants `IN_W=12`, `MAG_W=11`, `EXP_W=3`, `SIG_W=4`, `EXP_MAX=3'd7`, `MAG_SAT=11'h7FF`;
  - the state enum (IDLE, SHIFT, DONE).
- One combinational sub-module, `abs_sat`: 12-bit two's complement → 11-bit saturated magnitude. It is reusable by other converter stages.
- FSM, shift register and exponent counter live in the top module.

## Test plan
- 12'h000 → sign 0, exp 0, significand 0000, xbit 0; `out_valid` 8 cycles after accept.
- 12'h7FF → sign 0, exp 7, significand 1111, xbit 1; `out_valid` 1 cycle after accept.
- 12'h800 → magnitude saturates; sign 1, exp 7, significand 1111, xbit 1; latency 1.
- 12'h02C (44) → sign 0, exp 2, significand 1011, xbit 0; latency 6.
- 12'hFD2 (-46) → sign 1, exp 2, significand 1011, xbit 1; latency 6.
- Backpressure, using 12'hFD2 followed by a second `in_valid` sample:
  - Hold `out_ready=0` for 5 cycles in DONE → outputs and `out_valid` stay stable, `in_ready=0`, and the second sample is not accepted.
  - Raise `out_ready` → `in_ready=1` next cycle and the second sample is accepted.
- Assert `rst` for 1 cycle during SHIFT of 12'h001 → all outputs 0 after that edge, `in_ready=1` the cycle after release, and no `out_valid` for the aborted sample.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the 8-bit floating-point converter stages.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fp_pkg;

   localparam int IN_W  = 12;  // two's-complement sample width
   localparam int MAG_W = 11;  // magnitude width after removing the sign
   localparam int EXP_W = 3;   // exponent width
   localparam int SIG_W = 4;   // significand width (leading one included)

   localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;
   localparam logic [MAG_W-1:0] MAG_SAT = 11'h7FF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/abs_sat.sv
// Two's-complement to saturated magnitude; the most negative code clamps to all-ones.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input.
//
// Ports:
//   value     in  IN_W  two's-complement sample
//   magnitude out MAG_W |value|, with -2^(IN_W-1) mapped to MAG_SAT
module abs_sat
   import fp_pkg::*;
(
   input  logic [IN_W-1:0]  value,
   output logic [MAG_W-1:0] magnitude
);

   logic [IN_W-1:0] negated;

   always_comb begin
      negated   = '0 - value;
      magnitude = value[MAG_W-1:0];
      if (value[IN_W-1]) begin
         // -2048 negates to itself; its low bits would read as zero, so clamp.
         if (value == {1'b1, {(IN_W-1){1'b0}}})
            magnitude = MAG_SAT;
         else
            magnitude = negated[MAG_W-1:0];
      end
   end

endmodule

// File: rtl/fp_normalize_serial.sv
// Serial normalizer: sample -> sign, exponent, 4-bit significand and round bit, one shift per cycle.
// Latency: 1..8 cycles from accept to out_valid (1 + number of left shifts needed).
// Backpressure: result held stable in DONE until out_ready; no new sample accepted until then.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_data/in_valid/in_ready   12-bit two's-complement sample handshake
//   out_sign/out_exp/
//   out_significand/out_xbit    registered result fields
//   out_valid/out_ready         result handshake
module fp_normalize_serial
   import fp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [SIG_W-1:0] out_significand,
   output logic             out_xbit,
   output logic             out_valid,
   input  logic             out_ready
);

   state_t           state;
   state_t           state_nxt;

   logic [MAG_W-1:0] mag;
   logic [MAG_W-1:0] mag_in;
   logic [EXP_W-1:0] exp_cnt;
   logic             sign;

   logic             accept;
   logic             norm_hit;

   abs_sat u_abs_sat (
      .value     (in_data),
      .magnitude (mag_in)
   );

   assign accept   = in_valid && in_ready;
   // Stop once the leading one reaches the top, or the exponent bottoms out
   // (denormal / zero input keeps whatever bits are there).
   assign norm_hit = mag[MAG_W-1] || (exp_cnt == '0);

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = SHIFT;
         SHIFT:   if (norm_hit)  state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // FSM outputs; in_ready is masked by rst so nothing is accepted on a reset edge.
   always_comb begin
      in_ready  = (state == IDLE) && !rst;
      out_valid = (state == DONE);
   end

   // Shift register, exponent counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         mag             <= '0;
         exp_cnt         <= '0;
         sign            <= 1'b0;
         out_sign        <= 1'b0;
         out_exp         <= '0;
         out_significand <= '0;
         out_xbit        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sign    <= in_data[IN_W-1];
                  mag     <= mag_in;
                  exp_cnt <= EXP_MAX;
               end
            end
            SHIFT: begin
               if (norm_hit) begin
                  out_sign        <= sign;
                  out_exp         <= exp_cnt;
                  out_significand <= mag[MAG_W-1 -: SIG_W];
                  out_xbit        <= mag[MAG_W-1-SIG_W];
               end else begin
                  mag     <= {mag[MAG_W-2:0], 1'b0};
                  exp_cnt <= exp_cnt - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_normalize_serial.sv
// Scoreboard bench for fp_normalize_serial: directed samples with hand-computed results.
// Latency: n/a.
// Backpressure: exercises a held out_ready=0 window and a reset abort mid-shift.
module tb_fp_normalize_serial;

   typedef struct {
      logic       sign;
      logic [2:0] e;
      logic [3:0] sig;
      logic       x;
      int         lat;
      int         acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        out_sign;
   logic [2:0]  out_exp;
   logic [3:0]  out_significand;
   logic        out_xbit;
   logic        out_valid;
   logic        out_ready = 1'b1;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   exp_t sb[$];

   fp_normalize_serial dut (
      .clk             (clk),
      .rst             (rst),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .out_sign        (out_sign),
      .out_exp         (out_exp),
      .out_significand (out_significand),
      .out_xbit        (out_xbit),
      .out_valid       (out_valid),
      .out_ready       (out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   task automatic wait_ready();
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) timeout("wait_in_ready");
   endtask

   task automatic push(input logic s, input logic [2:0] e, input logic [3:0] sg,
                       input logic x, input int lat);
      exp_t item;
      item.sign = s;
      item.e    = e;
      item.sig  = sg;
      item.x    = x;
      item.lat  = lat;
      item.acc  = cyc;
      sb.push_back(item);
   endtask

   task automatic send(input logic [11:0] d, input logic s, input logic [2:0] e,
                       input logic [3:0] sg, input logic x, input int lat);
      wait_ready();
      in_data  = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      push(s, e, sg, x, lat);
      in_valid = 1'b0;
   endtask

   // Monitor: pops on each new out_valid, then checks every cycle the result is held.
   exp_t cur;
   logic have_cur = 1'b0;
   logic prev_vld = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_vld = 1'b0;
         have_cur = 1'b0;
      end else begin
         if (out_valid && !prev_vld) begin
            if (sb.size() == 0) begin
               have_cur = 1'b0;
               n_vec++;
               n_err++;
               $display("FAIL spurious_valid: out_valid with no sample pending (cycle %0d)", cyc);
            end else begin
               cur      = sb.pop_front();
               have_cur = 1'b1;
               chk("latency", cyc - cur.acc, cur.lat);
            end
         end
         if (out_valid && have_cur) begin
            chk("out_sign", int'(out_sign), int'(cur.sign));
            chk("out_exp", int'(out_exp), int'(cur.e));
            chk("out_significand", int'(out_significand), int'(cur.sig));
            chk("out_xbit", int'(out_xbit), int'(cur.x));
         end
         prev_vld = out_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;

      // Reset behaviour
      repeat (3) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_in_ready_release", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_outputs", int'({out_sign, out_exp, out_significand, out_xbit}), 0);

      // Directed vectors: data, sign, exp, significand, xbit, latency
      send(12'h000, 1'b0, 3'd0, 4'b0000, 1'b0, 8);
      send(12'h7FF, 1'b0, 3'd7, 4'b1111, 1'b1, 1);
      send(12'h800, 1'b1, 3'd7, 4'b1111, 1'b1, 1);
      send(12'h02C, 1'b0, 3'd2, 4'b1011, 1'b0, 6);
      send(12'hFD2, 1'b1, 3'd2, 4'b1011, 1'b1, 6);
      send(12'h040, 1'b0, 3'd3, 4'b1000, 1'b0, 5);
      send(12'hFFF, 1'b1, 3'd0, 4'b0001, 1'b0, 8);

      // Backpressure: hold the FD2 result while a second sample waits
      wait_ready();
      out_ready = 1'b0;
      in_data   = 12'hFD2;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      push(1'b1, 3'd2, 4'b1011, 1'b1, 6);
      in_data = 12'h7FF;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) timeout("bp_wait_valid");
      repeat (5) begin
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_out_valid", int'(out_valid), 1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_in_ready", int'(in_ready), 1);
      chk("bp_release_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      push(1'b0, 3'd7, 4'b1111, 1'b1, 1);
      in_valid = 1'b0;

      // Reset abort in the middle of shifting 12'h001
      wait_ready();
      in_data  = 12'h001;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_outputs", int'({out_sign, out_exp, out_significand, out_xbit}), 0);
      chk("abort_in_ready_in_rst", int'(in_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_in_ready_release", int'(in_ready), 1);
      repeat (12) @(negedge clk);

      // Recovery after abort
      send(12'h02C, 1'b0, 3'd2, 4'b1011, 1'b0, 6);

      t = 0;
      while ((sb.size() != 0 || out_valid) && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
